// File: rtl/muldiv.sv
// muldiv: iterative RISC-V M-extension multiply/divide unit.
// Shift-add multiply and restoring divide share one 2*XLEN accumulator, one bit per cycle.
module muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg1_q, neg1_d;
    logic              neg2_q, neg2_d;
    logic [XLEN-1:0]   mag2_q, mag2_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              valid_q, valid_d;

    logic              accept;
    logic              sign1_in, sign2_in;
    logic              div_by_zero, overflow;
    logic [XLEN-1:0]   mag1_in, mag2_in;
    logic [XLEN:0]     add_sum, shifted, diff;
    logic [2*XLEN-1:0] acc_step, product;
    logic [XLEN-1:0]   quotient, remainder, final_res;

    assign ready_o = (state_q == S_IDLE);
    assign valid_o = valid_q;
    assign result  = result_q;

    // Operand conditioning at acceptance and one iteration step of the accumulator.
    always_comb begin
        accept      = valid_i && ready_o && !flush_i;
        sign1_in    = operand1[XLEN-1] &&
                      (op_i == 3'd1 || op_i == 3'd2 || op_i == 3'd4 || op_i == 3'd6);
        sign2_in    = operand2[XLEN-1] && (op_i == 3'd1 || op_i == 3'd4 || op_i == 3'd6);
        mag1_in     = sign1_in ? -operand1 : operand1;
        mag2_in     = sign2_in ? -operand2 : operand2;
        div_by_zero = op_i[2] && (operand2 == '0);
        overflow    = (op_i == 3'd4 || op_i == 3'd6) &&
                      (operand1 == MIN_NEG) && (operand2 == ALL_ONES);

        add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag2_q} : '0);
        shifted = acc_q[2*XLEN-1:XLEN-1];
        diff    = shifted - {1'b0, mag2_q};
        if (op_q[2]) begin
            acc_step = {(diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0]),
                        acc_q[XLEN-2:0], ~diff[XLEN]};
        end else begin
            acc_step = {add_sum, acc_q[XLEN-1:1]};
        end

        product   = (neg1_q ^ neg2_q) ? -acc_step : acc_step;
        quotient  = (neg1_q ^ neg2_q) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        remainder = neg1_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:             final_res = product[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_res = product[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_res = quotient;
            default:          final_res = remainder;
        endcase
    end

    // Sequencing; the result is registered on the edge entering DONE so it is valid with the pulse.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        mag2_d   = mag2_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = 1'b0;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_d   = op_i;
                        neg1_d = sign1_in;
                        neg2_d = sign2_in;
                        mag2_d = mag2_in;
                        acc_d  = {{XLEN{1'b0}}, mag1_in};
                        cnt_d  = CNT_INIT;
                        if (div_by_zero) begin
                            state_d  = S_DONE;
                            valid_d  = 1'b1;
                            result_d = op_i[1] ? operand1 : ALL_ONES;
                        end else if (overflow) begin
                            state_d  = S_DONE;
                            valid_d  = 1'b1;
                            result_d = op_i[1] ? '0 : operand1;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_d = acc_step;
                    if (cnt_q == '0) begin
                        state_d  = S_DONE;
                        valid_d  = 1'b1;
                        result_d = final_res;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            mag2_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            mag2_q   <= mag2_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end
endmodule

// File: doc/muldiv.md
# muldiv

Iterative, parametrised-width integer multiply/divide unit implementing the RISC-V M-extension operations. It is a multi-cycle companion to the single-cycle ALU and sits beside it in the execute stage, selected by the same funct3 encoding. Operands are accepted through a valid/ready handshake and the result is returned as a one-cycle `valid_o` pulse. An in-flight operation can be aborted with `flush_i`.

## Interface
- `XLEN`, 32: operand and result width; power of two, ≥ 8.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `valid_i`  in  1  request valid.
- `ready_o`  out  1  unit idle; a request is accepted when `valid_i && ready_o && !flush_i`.
- `op_i`  in  3  funct3:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `operand1`  in  XLEN  rs1 value (multiplicand / dividend); sampled at acceptance only.
- `operand2`  in  XLEN  rs2 value (multiplier / divisor); sampled at acceptance only.
- `flush_i`  in  1  abort any in-flight operation.
- `valid_o`  out  1  single-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  registered result; holds its value until the next `valid_o`.

## Operation
- States: IDLE, CALC, DONE.
- `ready_o` = (state == IDLE).
- IDLE → CALC on acceptance. At acceptance the unit latches:
  - op;
  - operand signs: signed for MULH and DIV/REM; operand1 only for MULHSU; none for the others;
  - operand magnitudes, with the absolute value taken when the operand is signed and negative;
  - iteration counter := XLEN−1.
- IDLE → DONE directly on acceptance in these special cases:
  - divide by zero: DIV/DIVU → all ones; REM/REMU → operand1.
  - signed overflow (DIV/REM, operand1 = 1 followed by XLEN−1 zeros, operand2 = all ones): DIV → operand1; REM → 0.
- CALC: one iteration per cycle; the counter decrements and CALC → DONE when the counter is 0 (XLEN iterations).
  - Multiply: unsigned shift-add into a 2·XLEN accumulator.
  - Divide: restoring division; each iteration produces one quotient bit and a partial remainder of XLEN+1 bits.
- DONE: apply sign correction, register `result`, pulse `valid_o`, then go to IDLE.
  - Product: negated (2·XLEN two's complement) if the operand signs differ. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Quotient: negated if the signs differ.
  - Remainder: takes the sign of the dividend.
- Flush: `flush_i` in any state → IDLE on the next edge. No `valid_o` is produced, and `result` keeps its previous value. If `flush_i` and `valid_i` are high in the same cycle, no request is accepted.
- Reset (any state, including mid-operation): state IDLE, `valid_o` 0, `result` 0, counter 0, latched operands 0. `ready_o` is 1 from the first cycle after reset. No `valid_o` is produced for the aborted operation.
- All arithmetic wraps modulo 2^XLEN (MUL), per the RISC-V M specification; there are no exceptions and no flags.

## Timing
- Acceptance edge is cycle 0.
- Normal op: CALC occupies cycles 1..XLEN; `valid_o` is high in cycle XLEN+1; `ready_o` is high again in cycle XLEN+2.
- Special cases (divide by zero, overflow): `valid_o` in cycle 1; `ready_o` in cycle 2.
- `ready_o` is low from cycle 1 until the cycle after `valid_o`.
- `valid_o` is exactly one cycle wide. The unit has no output back-pressure; the consumer must take the result in the pulse cycle.
- Minimum request spacing: XLEN+2 cycles normal; 2 cycles for special cases.
- Outputs are registered; there are no combinational paths from the inputs to `valid_o` or `result`. `ready_o` is derived from state only.

## Test plan
- MUL, 7 × 0xFFFFFFFD (−3), XLEN=32 → `valid_o` in cycle 33, `result` 0xFFFFFFEB; `ready_o` is 0 in cycles 1–33 and 1 in cycle 34.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide:
  - DIV −7 / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- Special cases, each with `valid_o` in cycle 1:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- Abort and reset:
  - Assert `flush_i` in cycle 10 of a DIV → no `valid_o`, `ready_o` = 1 in cycle 11, `result` unchanged; a DIVU 9 / 3 accepted in cycle 11 returns 3 in cycle 44.
  - Assert `rst_i` mid-MUL → `result` 0, no pulse.
  - `valid_i` and `flush_i` high together → not accepted.
- XLEN=8 instance: MUL 0x0F × 0x11 → 0xFF, `valid_o` in cycle 9; randomised all-op comparison against a reference model for 10k operands.
